// File: rtl/axis64_kvs_engine.sv
// axis64_kvs_engine: request/response key-value store between two 64-bit
// AXI4-Stream interfaces. One request packet (GET/SET/DEL) is parsed at a
// time against a direct-mapped on-chip store; exactly one response packet is
// produced per request packet.
// Optional build macro KVS_STATS_EN adds GET hit/miss counters and the STATS
// opcode (04); without it opcode 04 is an unknown opcode.
module axis64_kvs_engine #(
    parameter int unsigned NUM_SLOTS       = 64,
    parameter int unsigned MAX_VALUE_BEATS = 8
) (
    input  logic        clk_150,
    input  logic        clk_150_rst_n,
    input  logic [63:0] from_net_tdata,
    input  logic [7:0]  from_net_tkeep,
    input  logic [63:0] from_net_tuser,
    input  logic        from_net_tvalid,
    input  logic        from_net_tlast,
    output logic        from_net_tready,
    output logic [63:0] to_net_tdata,
    output logic [7:0]  to_net_tkeep,
    output logic [63:0] to_net_tuser,
    output logic        to_net_tvalid,
    output logic        to_net_tlast,
    input  logic        to_net_tready
);

    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
    localparam int unsigned BI_W  = (MAX_VALUE_BEATS > 1) ? $clog2(MAX_VALUE_BEATS) : 1;
    localparam logic [7:0]  MAXB  = 8'(MAX_VALUE_BEATS);

    localparam logic [7:0] OP_GET   = 8'h01;
    localparam logic [7:0] OP_SET   = 8'h02;
    localparam logic [7:0] OP_DEL   = 8'h03;
    localparam logic [7:0] OP_STATS = 8'h04;

    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_MISS = 8'h01;
    localparam logic [7:0] ST_ERR  = 8'h02;

    localparam logic [2:0] HDR      = 3'd0;
    localparam logic [2:0] RX_VAL   = 3'd1;
    localparam logic [2:0] DRAIN    = 3'd2;
    localparam logic [2:0] RESP_HDR = 3'd3;
    localparam logic [2:0] RESP_VAL = 3'd4;

    logic [2:0]       state;
    logic             run;
    logic [7:0]       op_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [7:0]       rlen_q;
    logic [31:0]      key_q;
    logic [IDX_W-1:0] idx_q;

    logic [NUM_SLOTS-1:0] valid_q;
    logic [31:0]          tag_mem  [NUM_SLOTS];
    logic [7:0]           len_mem  [NUM_SLOTS];
    logic [63:0]          data_mem [NUM_SLOTS][MAX_VALUE_BEATS];

    logic [63:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [63:0] rd_data;

`ifdef KVS_STATS_EN
    logic [31:0] hits;
    logic [31:0] misses;
`endif

    logic             in_fire;
    logic             out_fire;
    logic [7:0]       hdr_op;
    logic [7:0]       hdr_len;
    logic [31:0]      hdr_key;
    logic [IDX_W-1:0] hdr_idx;
    logic             hdr_hit;
    logic             wr_en;
    logic             beat_done;
    logic             commit;

    logic [2:0]  h_next;
    logic [7:0]  h_status;
    logic [7:0]  h_rlen;
    logic        h_clr;
    logic        h_hit;
    logic        h_miss;
    logic [63:0] h_rd;
    logic [7:0]  nxt_beat;
    logic [63:0] rd_next;
    logic        unused_in;

    assign unused_in = ^{from_net_tkeep, from_net_tuser};

    assign from_net_tready = run && (state == HDR || state == RX_VAL || state == DRAIN);
    assign to_net_tdata    = out_data;
    assign to_net_tvalid   = out_valid;
    assign to_net_tlast    = out_last;
    assign to_net_tkeep    = out_valid ? 8'hFF : 8'h00;
    assign to_net_tuser    = '0;

    assign in_fire   = from_net_tvalid && from_net_tready;
    assign out_fire  = out_valid && to_net_tready;
    assign hdr_op    = from_net_tdata[63:56];
    assign hdr_len   = from_net_tdata[55:48];
    assign hdr_key   = from_net_tdata[31:0];
    assign hdr_idx   = from_net_tdata[IDX_W-1:0];
    assign hdr_hit   = valid_q[hdr_idx] && (tag_mem[hdr_idx] == hdr_key);
    assign wr_en     = (state == RX_VAL) && in_fire;
    assign beat_done = (cnt_q + 8'd1 == len_q);
    assign commit    = wr_en && from_net_tlast && beat_done;

    // Decide the outcome of a header beat: next state, status, returned length.
    always_comb begin
        h_next   = RESP_HDR;
        h_status = ST_ERR;
        h_rlen   = 8'd0;
        h_clr    = 1'b0;
        h_hit    = 1'b0;
        h_miss   = 1'b0;
        h_rd     = data_mem[hdr_idx][0];
        if (from_net_tlast) begin
            case (hdr_op)
                OP_GET: begin
                    if (hdr_hit) begin
                        h_status = ST_OK;
                        h_rlen   = len_mem[hdr_idx];
                        h_hit    = 1'b1;
                    end else begin
                        h_status = ST_MISS;
                        h_miss   = 1'b1;
                    end
                end
                OP_DEL: begin
                    h_status = hdr_hit ? ST_OK : ST_MISS;
                    h_clr    = hdr_hit;
                end
`ifdef KVS_STATS_EN
                OP_STATS: begin
                    h_status = ST_OK;
                    h_rlen   = 8'd1;
                    h_rd     = {hits, misses};
                end
`endif
                default: h_status = ST_ERR;
            endcase
        end else if (hdr_op == OP_SET && hdr_len != 8'd0 && hdr_len <= MAXB) begin
            h_next = RX_VAL;
        end else begin
            h_next = DRAIN;
        end
    end

    // Address of the value beat to prefetch behind the one being presented.
    always_comb begin
        nxt_beat = (state == RESP_HDR) ? 8'd1 : cnt_q + 8'd1;
        rd_next  = (nxt_beat < MAXB) ? data_mem[idx_q][nxt_beat[BI_W-1:0]] : '0;
    end

    // Value/tag/length storage; not reset, only the valid bits are.
    always_ff @(posedge clk_150) begin
        if (wr_en) begin
            data_mem[idx_q][cnt_q[BI_W-1:0]] <= from_net_tdata;
        end
        if (commit) begin
            tag_mem[idx_q] <= key_q;
            len_mem[idx_q] <= len_q;
        end
    end

    // Request parsing, slot valid bits and response sequencing.
    always_ff @(posedge clk_150 or negedge clk_150_rst_n) begin
        if (!clk_150_rst_n) begin
            state     <= HDR;
            run       <= 1'b0;
            op_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rlen_q    <= '0;
            key_q     <= '0;
            idx_q     <= '0;
            valid_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rd_data   <= '0;
`ifdef KVS_STATS_EN
            hits      <= '0;
            misses    <= '0;
`endif
        end else begin
            run <= 1'b1;
            case (state)
                HDR: begin
                    if (in_fire) begin
                        op_q   <= hdr_op;
                        len_q  <= hdr_len;
                        key_q  <= hdr_key;
                        idx_q  <= hdr_idx;
                        cnt_q  <= '0;
                        rlen_q <= h_rlen;
                        state  <= h_next;
                        if (h_clr) valid_q[hdr_idx] <= 1'b0;
                        if (h_next == RESP_HDR) begin
                            out_valid <= 1'b1;
                            out_data  <= {hdr_op, h_rlen, h_status, 8'h00, hdr_key};
                            out_last  <= (h_rlen == 8'd0);
                            rd_data   <= h_rd;
                        end
`ifdef KVS_STATS_EN
                        if (h_hit)  hits   <= hits + 32'd1;
                        if (h_miss) misses <= misses + 32'd1;
`endif
                    end
                end
                RX_VAL: begin
                    if (in_fire) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (from_net_tlast) begin
                            state     <= RESP_HDR;
                            rlen_q    <= '0;
                            out_valid <= 1'b1;
                            out_last  <= 1'b1;
                            valid_q[idx_q] <= beat_done;
                            out_data  <= {op_q, 8'h00, beat_done ? ST_OK : ST_ERR, 8'h00, key_q};
                        end else if (beat_done) begin
                            // LEN beats arrived but the packet goes on: slot is void.
                            valid_q[idx_q] <= 1'b0;
                            state          <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (in_fire && from_net_tlast) begin
                        state     <= RESP_HDR;
                        rlen_q    <= '0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                        out_data  <= {op_q, 8'h00, ST_ERR, 8'h00, key_q};
                    end
                end
                RESP_HDR, RESP_VAL: begin
                    if (out_fire) begin
                        if (out_last) begin
                            state     <= HDR;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                        end else begin
                            state    <= RESP_VAL;
                            out_data <= rd_data;
                            out_last <= (nxt_beat == rlen_q);
                            cnt_q    <= nxt_beat;
                            rd_data  <= rd_next;
                        end
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_axis64_kvs_engine.sv
// Self-checking bench for axis64_kvs_engine: directed scenarios followed by
// randomized requests with random valid/ready gaps, checked against a
// slot-array reference model of the store.
module tb_axis64_kvs_engine;

    localparam int unsigned NUM_SLOTS = 64;
    localparam int unsigned MAXB      = 8;

    localparam logic [7:0] OP_GET = 8'h01;
    localparam logic [7:0] OP_SET = 8'h02;
    localparam logic [7:0] OP_DEL = 8'h03;
    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_MISS = 8'h01;
    localparam logic [7:0] ST_ERR  = 8'h02;

    logic        clk_150 = 1'b0;
    logic        clk_150_rst_n = 1'b0;
    logic [63:0] from_net_tdata = '0;
    logic [7:0]  from_net_tkeep = '0;
    logic [63:0] from_net_tuser = '0;
    logic        from_net_tvalid = 1'b0;
    logic        from_net_tlast = 1'b0;
    logic        from_net_tready;
    logic [63:0] to_net_tdata;
    logic [7:0]  to_net_tkeep;
    logic [63:0] to_net_tuser;
    logic        to_net_tvalid;
    logic        to_net_tlast;
    logic        to_net_tready = 1'b0;

    axis64_kvs_engine #(
        .NUM_SLOTS      (NUM_SLOTS),
        .MAX_VALUE_BEATS(MAXB)
    ) dut (
        .clk_150        (clk_150),
        .clk_150_rst_n  (clk_150_rst_n),
        .from_net_tdata (from_net_tdata),
        .from_net_tkeep (from_net_tkeep),
        .from_net_tuser (from_net_tuser),
        .from_net_tvalid(from_net_tvalid),
        .from_net_tlast (from_net_tlast),
        .from_net_tready(from_net_tready),
        .to_net_tdata   (to_net_tdata),
        .to_net_tkeep   (to_net_tkeep),
        .to_net_tuser   (to_net_tuser),
        .to_net_tvalid  (to_net_tvalid),
        .to_net_tlast   (to_net_tlast),
        .to_net_tready  (to_net_tready)
    );

    always #5 clk_150 = ~clk_150;

    int unsigned cyc = 0;
    always @(posedge clk_150) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int req_cnt = 0;
    int resp_cnt = 0;
    int stall_at = -1;
    int unsigned p_valid = 100;
    int unsigned p_ready = 100;

    // Reference store
    bit          m_valid [NUM_SLOTS];
    logic [31:0] m_tag   [NUM_SLOTS];
    logic [7:0]  m_len   [NUM_SLOTS];
    logic [63:0] m_data  [NUM_SLOTS][MAXB];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic [63:0] vals_g[$];
    logic [63:0] beats_g[$];
    logic [64:0] rq_g[$];
    bit          last_g;
    int unsigned acc_cyc_g;
    int unsigned first_cyc_g;
    bit          got_any_g;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_SLOTS); i++) m_valid[i] = 1'b0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    // Expected response beats ({tlast, tdata}) and store update for one request.
    task automatic model(input logic [7:0] op, input logic [7:0] len, input logic [31:0] key);
        int unsigned idx = key % NUM_SLOTS;
        int unsigned n   = vals_g.size();
        bit          hit = m_valid[idx] && (m_tag[idx] == key);
        logic [7:0]  st  = ST_ERR;
        logic [7:0]  rl  = 8'd0;
        logic [64:0] body[$];
        if (n == 0) begin
            if (op == OP_GET) begin
                if (hit) begin
                    st = ST_OK;
                    rl = m_len[idx];
                    for (int i = 0; i < int'(rl); i++)
                        body.push_back({(i == int'(rl) - 1), m_data[idx][i]});
                    m_hits++;
                end else begin
                    st = ST_MISS;
                    m_misses++;
                end
            end else if (op == OP_DEL) begin
                st = hit ? ST_OK : ST_MISS;
                if (hit) m_valid[idx] = 1'b0;
            end
`ifdef KVS_STATS_EN
            else if (op == 8'h04) begin
                st = ST_OK;
                rl = 8'd1;
                body.push_back({1'b1, m_hits, m_misses});
            end
`endif
        end else if (op == OP_SET && len >= 1 && len <= 8'(MAXB)) begin
            if (n == int'(len)) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = key;
                m_len[idx]   = len;
                for (int i = 0; i < int'(n); i++) m_data[idx][i] = vals_g[i];
                st = ST_OK;
            end else begin
                m_valid[idx] = 1'b0;
            end
        end
        rq_g.delete();
        rq_g.push_back({(rl == 8'd0), op, rl, st, 8'h00, key});
        foreach (body[i]) rq_g.push_back(body[i]);
    endtask

    task automatic send_req();
        int i = 0;
        int guard = 0;
        while (i < beats_g.size()) begin
            @(posedge clk_150); #1;
            from_net_tvalid = ($urandom_range(1, 100) <= p_valid);
            from_net_tdata  = beats_g[i];
            from_net_tlast  = last_g && (i == beats_g.size() - 1);
            from_net_tkeep  = 8'($urandom);
            from_net_tuser  = {$urandom, $urandom};
            @(negedge clk_150);
            if (from_net_tvalid && from_net_tready) begin
                i++;
                acc_cyc_g = cyc;
            end
            if (++guard > 4000) begin
                check_eq("send_timeout", i, beats_g.size());
                break;
            end
        end
        @(posedge clk_150); #1;
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
    endtask

    task automatic recv_resp();
        int   k = 0;
        int   guard = 0;
        int   stall_cnt = 0;
        bit   done = 1'b0;
        bit   prev_stall = 1'b0;
        logic [63:0] prev_d = '0;
        logic        prev_l = 1'b0;
        got_any_g = 1'b0;
        while (!done) begin
            @(posedge clk_150); #1;
            if (stall_at == k && stall_cnt < 5) begin
                to_net_tready = 1'b0;
                stall_cnt++;
            end else begin
                to_net_tready = ($urandom_range(1, 100) <= p_ready);
            end
            @(negedge clk_150);
            if (to_net_tvalid && !got_any_g) begin
                got_any_g   = 1'b1;
                first_cyc_g = cyc;
            end
            if (prev_stall) begin
                check_eq("hold_data", to_net_tdata, prev_d);
                check_eq("hold_ctl", {to_net_tvalid, to_net_tlast}, {1'b1, prev_l});
            end
            prev_stall = to_net_tvalid && !to_net_tready;
            prev_d     = to_net_tdata;
            prev_l     = to_net_tlast;
            if (to_net_tvalid && to_net_tready) begin
                if (k < rq_g.size()) begin
                    check_eq("resp_data", to_net_tdata, rq_g[k][63:0]);
                    check_eq("resp_last", to_net_tlast, rq_g[k][64]);
                end else begin
                    check_eq("resp_extra", k + 1, rq_g.size());
                end
                check_eq("resp_keep", to_net_tkeep, 8'hFF);
                check_eq("resp_user", to_net_tuser, 64'd0);
                k++;
                if (to_net_tlast) begin
                    done = 1'b1;
                    resp_cnt++;
                end
            end
            if (++guard > 4000) begin
                check_eq("resp_timeout", done, 1'b1);
                break;
            end
        end
        check_eq("resp_beats", k, rq_g.size());
    endtask

    task automatic do_req(input logic [7:0] op, input logic [7:0] len, input logic [31:0] key);
        beats_g.delete();
        beats_g.push_back({op, len, 16'($urandom), key});
        foreach (vals_g[i]) beats_g.push_back(vals_g[i]);
        last_g = 1'b1;
        model(op, len, key);
        fork
            send_req();
            recv_resp();
        join
        if (got_any_g) check_eq("latency", first_cyc_g, acc_cyc_g + 1);
        req_cnt++;
    endtask

    task automatic rand_vals(input int n);
        vals_g.delete();
        for (int i = 0; i < n; i++) vals_g.push_back({$urandom, $urandom});
    endtask

    task automatic apply_reset();
        @(posedge clk_150); #2;
        clk_150_rst_n = 1'b0;
        #1;
        check_eq("rst_tready", from_net_tready, 1'b0);
        check_eq("rst_tvalid", to_net_tvalid, 1'b0);
        check_eq("rst_tlast", to_net_tlast, 1'b0);
        check_eq("rst_tkeep", to_net_tkeep, 8'h00);
        check_eq("rst_tdata", to_net_tdata, 64'd0);
        check_eq("rst_tuser", to_net_tuser, 64'd0);
        model_reset();
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
        repeat (3) @(posedge clk_150);
        #1 clk_150_rst_n = 1'b1;
        @(negedge clk_150);
        check_eq("rdy_pre", from_net_tready, 1'b0);
        @(negedge clk_150);
        check_eq("rdy_post", from_net_tready, 1'b1);
    endtask

    initial begin
        logic [7:0]  op;
        logic [7:0]  len;
        logic [31:0] key;
        logic [7:0]  bad_ops [5];
        bad_ops[0] = 8'h00; bad_ops[1] = 8'h04; bad_ops[2] = 8'h05;
        bad_ops[3] = 8'h7F; bad_ops[4] = 8'hFF;

        apply_reset();

        // Directed scenarios
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0005);
        vals_g.delete();
        vals_g.push_back(64'hAAAA_AAAA_0000_000A);
        vals_g.push_back(64'hBBBB_BBBB_0000_000B);
        do_req(OP_SET, 8'd2, 32'h0000_0011);
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0011);
        rand_vals(8);
        do_req(OP_SET, 8'd8, 32'h0000_0051);
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0011);
        stall_at = 3;
        do_req(OP_GET, 8'd0, 32'h0000_0051);
        stall_at = -1;
        rand_vals(1);
        do_req(OP_SET, 8'd3, 32'h0000_0022);
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0022);
        rand_vals(2);
        do_req(8'h7F, 8'd0, 32'h0000_0033);
        rand_vals(9);
        do_req(OP_SET, 8'd9, 32'h0000_0044);
        vals_g.delete();
        do_req(OP_SET, 8'd1, 32'h0000_0044);
        do_req(OP_DEL, 8'd0, 32'h0000_0051);
        do_req(OP_DEL, 8'd0, 32'h0000_0051);
        do_req(8'h04, 8'd0, 32'h0000_0000);

`ifdef KVS_STATS_EN
        apply_reset();
        rand_vals(1);
        do_req(OP_SET, 8'd1, 32'h0000_0033);
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0033);
        do_req(OP_GET, 8'd0, 32'h0000_0033);
        do_req(OP_GET, 8'd0, 32'h0000_0034);
        do_req(8'h04, 8'd0, 32'h0000_0000);
`endif

        // Randomized traffic with bubbles and backpressure
        p_valid = 70;
        p_ready = 65;
        for (int n = 0; n < 250; n++) begin
            int unsigned r = $urandom_range(0, 9);
            key = 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 7));
            len = 8'($urandom);
            case (r)
                0, 1, 2: begin op = OP_SET; len = 8'($urandom_range(1, MAXB)); rand_vals(int'(len)); end
                3, 4, 5: begin op = OP_GET; vals_g.delete(); end
                6:       begin op = OP_DEL; vals_g.delete(); end
                7:       begin op = OP_SET; len = 8'($urandom_range(0, 12)); rand_vals($urandom_range(0, 10)); end
                8:       begin op = bad_ops[$urandom_range(0, 4)]; rand_vals($urandom_range(0, 3)); end
                default: begin op = ($urandom_range(0, 1) == 0) ? OP_GET : OP_DEL; rand_vals($urandom_range(1, 2)); end
            endcase
            do_req(op, len, key);
        end

        // Reset in the middle of a SET discards it and empties the store
        p_valid = 100;
        p_ready = 100;
        rand_vals(2);
        do_req(OP_SET, 8'd2, 32'h0000_0007);
        beats_g.delete();
        beats_g.push_back({OP_SET, 8'd4, 16'h0, 32'h0000_0007});
        beats_g.push_back(64'h1234_5678_9ABC_DEF0);
        last_g = 1'b0;
        send_req();
        apply_reset();
        vals_g.delete();
        do_req(OP_GET, 8'd0, 32'h0000_0007);

        check_eq("resp_vs_req", resp_cnt, req_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis64_kvs_engine.md
Name: axis64_kvs_engine

Overview:
- Single-clock key-value store engine between the network RX and TX AXI4-Stream (64-bit) interfaces.
- Parses one request packet at a time (GET/SET/DEL) against an internal direct-mapped on-chip value store.
- Emits exactly one response packet per request packet, so upstream can match requests to responses by counting tlast.

Parameters:
- NUM_SLOTS, 64: number of store slots; power of two; slot index = key[log2(NUM_SLOTS)-1:0].
- MAX_VALUE_BEATS, 8: maximum value length in 64-bit beats per slot (1..255).

Ports:
- clk_150  in  1  sole clock.
- clk_150_rst_n  in  1  asynchronous, active-low reset.
- from_net_tdata  in  64  request data.
- from_net_tkeep  in  8  byte enables; ignored (all beats treated as full).
- from_net_tuser  in  64  ignored.
- from_net_tvalid  in  1  request beat valid.
- from_net_tlast  in  1  last beat of request.
- from_net_tready  out  1  engine accepts request beat.
- to_net_tdata  out  64  response data.
- to_net_tkeep  out  8  always 8'hFF when valid.
- to_net_tuser  out  64  always 0.
- to_net_tvalid  out  1  response beat valid.
- to_net_tlast  out  1  last response beat.
- to_net_tready  in  1  downstream accepts response beat.

Behaviour:
- Request header (beat 0): [63:56] opcode (01 GET, 02 SET, 03 DEL), [55:48] LEN (value beats, SET only), [47:32] reserved, [31:0] KEY. A SET carries LEN value beats after the header.
- Response header: [63:56] opcode echo, [55:48] value beats returned, [47:40] status (00 OK, 01 MISS, 02 ERR), [39:32] 0, [31:0] KEY.
  - GET hit: header is followed by the stored value beats; tlast on the final value beat.
  - All other responses: single beat with tlast.
- Each slot holds a valid bit, a 32-bit tag (full key), an 8-bit length, and MAX_VALUE_BEATS x 64 data.
- FSM states: HDR, RX_VAL, DRAIN, RESP_HDR, RESP_VAL.
  - from_net_tready = 1 only in HDR, RX_VAL and DRAIN.
- HDR transitions:
  - Header with tlast=1 decides GET, DEL and bad opcode immediately, then goes to RESP_HDR.
  - SET header with tlast=0 and LEN in 1..MAX_VALUE_BEATS goes to RX_VAL.
  - Any other header with tlast=0 goes to DRAIN with status ERR.
- RX_VAL:
  - Writes beats into the slot as they arrive.
  - On tlast, if the beat count equals LEN: set valid=1, tag=KEY, length=LEN; status OK.
  - If tlast arrives early, or LEN beats are received without tlast: clear the slot's valid bit, set status ERR, and continue consuming to tlast (via DRAIN).
  - SET always overwrites the slot, with no tag check (eviction).
- SET header with tlast=1 and no value: ERR.
- GET: hit (valid && tag==KEY) returns OK plus LEN beats; otherwise MISS with length 0.
- DEL: hit clears valid, OK; otherwise MISS.
- DRAIN: accepts beats until tlast, then goes to RESP_HDR.
- Response latency:
  - to_net_tvalid rises in the cycle after the request's tlast beat is accepted.
  - GET value beats follow back-to-back while to_net_tready=1; the memory read is prefetched one beat ahead.
  - Outputs hold stable while tvalid=1 and tready=0.
- After the final response beat is accepted, return to HDR; the next request header can be accepted in the following cycle.
- Reset:
  - All outputs are 0.
  - All valid bits are cleared asynchronously; data and tag storage are not cleared.
  - FSM returns to HDR; from_net_tready rises on the first clock after reset release.
  - A reset mid-packet or mid-response discards that transaction; no response is produced.

Optional Feature:
- Macro: KVS_STATS_EN.
- Defined:
  - 32-bit hit and miss counters, cleared by reset, wrapping at 2^32.
  - GET hit increments hit; GET miss increments miss.
  - Opcode 04 (STATS, header-only) returns an OK header with length 1, then one beat {hits[31:0], misses[31:0]}.
- Undefined: opcode 04 is treated as unknown and returns ERR; no counters are built.

Test Plan:
- Reset, then GET key 0x00000005 -> single-beat response 01_00_01_00_00000005, tlast=1.
- SET key 0x11 with LEN=2, data A, B; then GET 0x11 -> responses 02_00_00..., then 01_02_00_00_00000011, A, B, with tlast on B.
- SET key 0x11, then SET key 0x51 (same index, NUM_SLOTS=64); GET 0x11 -> MISS; GET 0x51 -> OK with the new data.
- SET LEN=3 with a packet of only header plus 1 beat -> ERR; subsequent GET of that key -> MISS.
- Opcode 0x7F with 3 beats -> all 3 beats drained, one ERR response; hold to_net_tready=0 for 5 cycles mid-GET-value -> no beat lost or duplicated, response count equals request count.
- With KVS_STATS_EN: 2 hits + 1 miss, then STATS -> value beat 00000002_00000001.
